// File: rtl/ysyx_23060171_stage_buf_if.sv
// Valid/ready handshake bundle between two pipeline stages and the buffer that sits between them.
interface ysyx_23060171_stage_buf_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ysyx_23060171_stage_buf.sv
// Inter-stage circular queue with valid/ready handshake, optional empty-bypass,
// synchronous flush and a saturating stall-cycle counter.
module ysyx_23060171_stage_buf #(
  parameter int unsigned  WIDTH  = 32,
  parameter int unsigned  DEPTH  = 2,
  parameter bit           BYPASS = 1'b0,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  ysyx_23060171_stage_buf_if.slave   bus,
  output logic [CW-1:0]              count,
  output logic [31:0]                stall_cnt
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] cntQ, cntD;
  logic [PW-1:0] wrPtrQ, wrPtrD;
  logic [PW-1:0] rdPtrQ, rdPtrD;
  logic [31:0]   stallCntQ, stallCntD;

  logic             empty;
  logic             passThru;
  logic             inReady;
  logic             outValid;
  logic [WIDTH-1:0] outData;
  logic             push;
  logic             pop;
  logic             pushStore;
  logic             popStore;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake: a bypassed entry popped in the same cycle never touches storage.
  always_comb begin
    empty    = (cntQ == '0);
    passThru = BYPASS && empty;
    inReady  = rst && !flush && (cntQ < CW'(DEPTH));
    if (passThru) begin
      outValid = rst && !flush && bus.in_valid;
      outData  = rst ? bus.in_data : '0;
    end else begin
      outValid = rst && !flush && !empty;
      outData  = outValid ? mem[rdPtrQ] : '0;
    end
    push      = bus.in_valid && inReady;
    pop       = outValid && bus.out_ready;
    pushStore = push && !(passThru && pop);
    popStore  = pop && !passThru;
  end

  always_comb begin
    cntD   = cntQ;
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    if (flush) begin
      cntD   = '0;
      wrPtrD = '0;
      rdPtrD = '0;
    end else begin
      if (pushStore) wrPtrD = nextPtr(wrPtrQ);
      if (popStore)  rdPtrD = nextPtr(rdPtrQ);
      cntD = cntQ + CW'(pushStore) - CW'(popStore);
    end
    stallCntD = (outValid && !bus.out_ready && (stallCntQ != '1)) ? stallCntQ + 32'd1 : stallCntQ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntQ      <= '0;
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      stallCntQ <= '0;
    end else begin
      cntQ      <= cntD;
      wrPtrQ    <= wrPtrD;
      rdPtrQ    <= rdPtrD;
      stallCntQ <= stallCntD;
    end
  end

  // Payload storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (pushStore) mem[wrPtrQ] <= bus.in_data;
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = outData;
  assign count         = cntQ;
  assign stall_cnt     = stallCntQ;
endmodule

// File: tb/tb_ysyx_23060171_stage_buf.sv
// Directed bench for the stage buffer: depth-2 plain, depth-3 streaming and depth-2 bypass instances.
module tb_ysyx_23060171_stage_buf;
  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  cnt0, cnt1, cnt2;
  logic [31:0] st0, st1, st2;

  int checks   = 0;
  int failures = 0;

  ysyx_23060171_stage_buf_if #(.WIDTH(32)) b0 ();
  ysyx_23060171_stage_buf_if #(.WIDTH(32)) b1 ();
  ysyx_23060171_stage_buf_if #(.WIDTH(32)) b2 ();

  ysyx_23060171_stage_buf #(.WIDTH(32), .DEPTH(2), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b0), .count(cnt0), .stall_cnt(st0)
  );
  ysyx_23060171_stage_buf #(.WIDTH(32), .DEPTH(3), .BYPASS(1'b0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b1), .count(cnt1), .stall_cnt(st1)
  );
  ysyx_23060171_stage_buf #(.WIDTH(32), .DEPTH(2), .BYPASS(1'b1)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b2), .count(cnt2), .stall_cnt(st2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nextIn;
    int expOut;
    bit rdy;
    bit sawFull;

    rst = 1'b0; flush = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
    #2;
    chk("rst_count",     64'(cnt0), 64'd0);
    chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst_in_ready",  64'(b0.in_ready), 64'd0);
    chk("rst_out_data",  64'(b0.out_data), 64'd0);
    chk("rst_stall",     64'(st0), 64'd0);
    chk("rst_in_ready2", 64'(b2.in_ready), 64'd0);

    cyc(); rst = 1'b1; #1;
    chk("post_rst_in_ready0", 64'(b0.in_ready), 64'd1);
    chk("post_rst_in_ready1", 64'(b1.in_ready), 64'd1);
    chk("post_rst_in_ready2", 64'(b2.in_ready), 64'd1);

    // Fill depth-2 with A, B while stalled
    b0.in_valid = 1'b1; b0.in_data = 32'hA; b0.out_ready = 1'b0; #1;
    chk("t1_first_cycle_invisible", 64'(b0.out_valid), 64'd0);
    cyc(); b0.in_data = 32'hB; #1;
    chk("t1_count1", 64'(cnt0), 64'd1);
    chk("t1_valid1", 64'(b0.out_valid), 64'd1);
    chk("t1_data_a", 64'(b0.out_data), 64'hA);
    chk("t1_stall0", 64'(st0), 64'd0);
    cyc(); b0.in_valid = 1'b0; #1;
    chk("t1_count2", 64'(cnt0), 64'd2);
    chk("t1_full_in_ready", 64'(b0.in_ready), 64'd0);
    chk("t1_data_a_held", 64'(b0.out_data), 64'hA);
    chk("t1_stall1", 64'(st0), 64'd1);

    // Drain; full+pop must not accept C
    cyc(); b0.in_valid = 1'b1; b0.in_data = 32'hC; b0.out_ready = 1'b1; #1;
    chk("t2_stall2", 64'(st0), 64'd2);
    chk("t2_full_pop_no_accept", 64'(b0.in_ready), 64'd0);
    chk("t2_pop_a", 64'(b0.out_data), 64'hA);
    cyc(); b0.in_valid = 1'b0; #1;
    chk("t2_count1", 64'(cnt0), 64'd1);
    chk("t2_in_ready", 64'(b0.in_ready), 64'd1);
    chk("t2_pop_b", 64'(b0.out_data), 64'hB);
    chk("t2_stall_kept", 64'(st0), 64'd2);
    cyc(); b0.out_ready = 1'b0; #1;
    chk("t2_count0", 64'(cnt0), 64'd0);
    chk("t2_empty_valid", 64'(b0.out_valid), 64'd0);
    chk("t2_empty_data", 64'(b0.out_data), 64'd0);
    chk("t2_stall_idle", 64'(st0), 64'd2);

    // Depth-3 streaming 1..10 with toggling out_ready
    nextIn = 1; expOut = 1; rdy = 1'b1; sawFull = 1'b0;
    cyc();
    for (int i = 0; i < 60 && expOut <= 10; i++) begin
      b1.in_valid = (nextIn <= 10);
      b1.in_data = 32'(nextIn);
      b1.out_ready = rdy;
      #1;
      if (cnt1 == 2'd3) sawFull = 1'b1;
      if (b1.out_valid && b1.out_ready) begin
        chk("t3_order", 64'(b1.out_data), 64'(expOut));
        expOut++;
      end
      if (b1.in_valid && b1.in_ready) nextIn++;
      cyc();
      rdy = ~rdy;
    end
    b1.in_valid = 1'b0; b1.out_ready = 1'b0; #1;
    chk("t3_all_popped", 64'(expOut), 64'd11);
    chk("t3_saw_full", 64'(sawFull), 64'd1);
    chk("t3_count0", 64'(cnt1), 64'd0);

    // Bypass: pass-through, then store when stalled, then FIFO order with count>0
    cyc(); b2.in_valid = 1'b1; b2.in_data = 32'h55; b2.out_ready = 1'b1; #1;
    chk("t4_bypass_valid", 64'(b2.out_valid), 64'd1);
    chk("t4_bypass_data", 64'(b2.out_data), 64'h55);
    cyc(); b2.in_valid = 1'b0; #1;
    chk("t4_bypass_not_stored", 64'(cnt2), 64'd0);
    chk("t4_bypass_idle", 64'(b2.out_valid), 64'd0);
    cyc(); b2.in_valid = 1'b1; b2.in_data = 32'h55; b2.out_ready = 1'b0; #1;
    chk("t4_stalled_valid", 64'(b2.out_valid), 64'd1);
    chk("t4_stalled_data", 64'(b2.out_data), 64'h55);
    cyc(); b2.in_data = 32'h66; b2.out_ready = 1'b1; #1;
    chk("t4_stored_count", 64'(cnt2), 64'd1);
    chk("t4_stored_data", 64'(b2.out_data), 64'h55);
    cyc(); b2.in_valid = 1'b0; #1;
    chk("t4_pushpop_count", 64'(cnt2), 64'd1);
    chk("t4_fifo_order", 64'(b2.out_data), 64'h66);
    cyc(); b2.out_ready = 1'b0; #1;
    chk("t4_drained", 64'(cnt2), 64'd0);
    chk("t4_drained_valid", 64'(b2.out_valid), 64'd0);

    // Flush with two queued entries
    cyc(); b0.in_valid = 1'b1; b0.in_data = 32'h11; #1;
    cyc(); b0.in_data = 32'h22; #1;
    chk("t5_count1", 64'(cnt0), 64'd1);
    cyc(); flush = 1'b1; b0.in_data = 32'h33; #1;
    chk("t5_flush_in_ready", 64'(b0.in_ready), 64'd0);
    chk("t5_flush_out_valid", 64'(b0.out_valid), 64'd0);
    chk("t5_flush_count2", 64'(cnt0), 64'd2);
    chk("t5_stall3", 64'(st0), 64'd3);
    cyc(); flush = 1'b0; b0.in_valid = 1'b0; #1;
    chk("t5_after_count", 64'(cnt0), 64'd0);
    chk("t5_after_valid", 64'(b0.out_valid), 64'd0);
    chk("t5_after_in_ready", 64'(b0.in_ready), 64'd1);
    chk("t5_stall_retained", 64'(st0), 64'd3);
    cyc(); b0.in_valid = 1'b1; b0.in_data = 32'h44; #1;
    cyc(); b0.in_data = 32'h55; #1;
    chk("t5_new_head", 64'(b0.out_data), 64'h44);
    chk("t5_new_count", 64'(cnt0), 64'd1);
    cyc(); b0.in_valid = 1'b0; #1;
    chk("t5_count2", 64'(cnt0), 64'd2);
    chk("t5_stall4", 64'(st0), 64'd4);

    // Asynchronous reset mid-cycle
    #2; rst = 1'b0; #1;
    chk("t6_async_count", 64'(cnt0), 64'd0);
    chk("t6_async_valid", 64'(b0.out_valid), 64'd0);
    chk("t6_async_in_ready", 64'(b0.in_ready), 64'd0);
    chk("t6_async_data", 64'(b0.out_data), 64'd0);
    chk("t6_async_stall", 64'(st0), 64'd0);
    cyc(); rst = 1'b1; #1;
    chk("t6_release_in_ready", 64'(b0.in_ready), 64'd1);

    // Saturation of the stall counter from a preloaded value
    force dut0.stallCntQ = 32'hFFFF_FFFD;
    cyc();
    release dut0.stallCntQ;
    #1;
    chk("t6_preload", 64'(st0), 64'hFFFF_FFFD);
    b0.in_valid = 1'b1; b0.in_data = 32'h99; b0.out_ready = 1'b0;
    cyc(); b0.in_valid = 1'b0; #1;
    chk("t6_push_no_stall", 64'(st0), 64'hFFFF_FFFD);
    chk("t6_valid", 64'(b0.out_valid), 64'd1);
    cyc(); #1;
    chk("t6_stall_fffe", 64'(st0), 64'hFFFF_FFFE);
    cyc(); #1;
    chk("t6_stall_ffff", 64'(st0), 64'hFFFF_FFFF);
    cyc(); #1;
    chk("t6_saturated", 64'(st0), 64'hFFFF_FFFF);
    cyc(); #1;
    chk("t6_still_saturated", 64'(st0), 64'hFFFF_FFFF);
    chk("t6_head_stable", 64'(b0.out_data), 64'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_23060171_stage_buf.md
Name: ysyx_23060171_stage_buf

Overview:
Parametrised inter-stage buffer with a valid/ready handshake. It replaces the bare wire bundles between IFU/IDU/EXU/LSU/WBU so that stages can stall independently. Each instance carries one packed stage bundle of WIDTH bits through a DEPTH-entry circular queue. It adds optional same-cycle bypass, synchronous flush for redirects and traps, and a stall-cycle counter for performance analysis.

Parameters:
WIDTH, 32, bit width of the packed stage bundle (1..512)
DEPTH, 2, number of queue entries (1..16; need not be a power of two)
BYPASS, 0, 1 = when empty, input is presented to the output in the same cycle; 0 = minimum latency of 1 cycle
CW, $clog2(DEPTH+1), width of the count output (derived; not overridable)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset (0 = in reset)
flush  input  1  synchronous discard of all queued entries
in_valid  input  1  upstream stage presents in_data
in_ready  output  1  buffer can accept an entry this cycle
in_data  input  WIDTH  upstream bundle
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream stage accepts out_data
out_data  output  WIDTH  head bundle
count  output  CW  number of stored entries, 0..DEPTH
stall_cnt  output  32  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, stall_cnt=0; out_valid=0, in_ready=0, out_data=0. Storage array is not reset.
- After rst deasserts: in_ready=1 from the first cycle.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. A transfer occurs only on the rising edge.
- in_ready = (count<DEPTH) & ~flush & rst. It has no combinational dependency on out_ready, so full+pop in the same cycle does not accept an entry.
- Pointers advance by 1 and wrap from DEPTH-1 to 0 explicitly, including non-power-of-two DEPTH.
- count next value is count + push_stored - pop_stored. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- BYPASS=0:
  - out_valid = (count!=0) & ~flush.
  - out_data = mem[rd_ptr] when out_valid=1, else 0.
  - An entry pushed in cycle N is visible in cycle N+1.
- BYPASS=1, count==0:
  - out_valid = in_valid & ~flush; out_data = in_data.
  - If out_ready=1, the entry passes through and is not stored (count stays 0).
  - If out_ready=0, the entry is stored and shown from mem the next cycle.
- BYPASS=1, count>0: behaves exactly as BYPASS=0, preserving FIFO order.
- Flush (flush=1 in cycle N):
  - Combinationally forces out_valid=0 and in_ready=0; no push or pop occurs in cycle N.
  - At edge N: count=0, rd_ptr=wr_ptr=0. Cycle N+1 is empty.
  - stall_cnt is not cleared by flush.
- stall_cnt increments by 1 each cycle with out_valid & ~out_ready and saturates at 32'hFFFF_FFFF. Only reset clears it.
- Reset asserted mid-operation: all queued entries are lost immediately and outputs take their reset values asynchronously.
- Protocol: once out_valid=1, out_data stays stable until popped or flushed. Upstream may drop in_valid without a handshake; the buffer must not require in_valid to be held.

Test Plan:
1. BYPASS=0, DEPTH=2: push 32'hA, then 32'hB on consecutive cycles with out_ready=0 -> count=2, in_ready=0, out_data=32'hA, stall_cnt increments each cycle.
2. Continuing from (1): raise out_ready for 2 cycles -> pops 32'hA then 32'hB; count 2→1→0; in_ready=1 after the first pop; out_valid=0 afterwards.
3. DEPTH=3: stream 10 entries 1..10 with out_ready toggling 1,0,1,0,... -> output order exactly 1..10; pointers wrap at 2→0 with no loss or duplication.
4. BYPASS=1, empty, in_valid=1, in_data=32'h55, out_ready=1 -> out_valid=1 and out_data=32'h55 in the same cycle; count stays 0. Repeat with out_ready=0 -> count=1 next cycle, out_data=32'h55.
5. Queue holding 2 entries, flush=1 for one cycle while in_valid=1 -> in_ready=0 and out_valid=0 that cycle; count=0 next cycle; the flushed-cycle input is not stored; stall_cnt retained.
6. Assert rst=0 asynchronously mid-cycle with count=2 -> count, out_valid, in_ready and out_data go to 0 without waiting for a clock edge. With stall_cnt preloaded near 32'hFFFF_FFFF, stalling saturates it rather than wrapping.
